// File: rtl/parity_uart_pkg.sv
// Shared definitions for the XOR-parity UART link: state encoding, line levels
// and the parity helper used by both the transmitter and the receiver.
package parity_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  // Widest word either end supports; narrower words are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int MAX_DATA_BITS = 9;

  // Parity bit the transmitter appends for a word.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, with a selectable
// reset level so idle-high and idle-low lines both come out of reset quiet.
module sync_2ff #(
  parameter int              WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/parity_uart_rx.sv
// XOR-parity UART receiver: start, DATA_BITS data (LSB first), parity, stop.
// Oversamples the synchronized line and reports each word with error flags.
module parity_uart_rx
  import parity_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  logic rx_s;

  uart_state_e          state_q,  state_d;
  logic [CW-1:0]        cnt_q,    cnt_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic                 perr_pend_q, perr_pend_d;
  logic                 armed_q,  armed_d;
  logic [1:0]           flush_q,  flush_d;
  logic [DATA_BITS-1:0] data_q,   data_d;
  logic                 valid_q,  valid_d;
  logic                 perr_q,   perr_d;
  logic                 ferr_q,   ferr_d;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (IDLE_LVL)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    perr_pend_d = perr_pend_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    perr_d      = perr_q;
    ferr_d      = ferr_q;

    // The synchronizer's reset level is not an observation of the line, so
    // arming waits until both flops have been loaded from rx_i.
    flush_d = {flush_q[0], 1'b1};
    armed_d = armed_q | (flush_q[1] & (rx_s == IDLE_LVL));

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (armed_q && (rx_s == START_LVL)) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (rx_s == START_LVL) begin
            state_d  = ST_DATA;
            bitcnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bitcnt_q == BIT_LAST) begin
            state_d = ST_PARITY;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (cnt_q == CNT_END) begin
          cnt_d       = '0;
          perr_pend_d = parity_bit(MAX_DATA_BITS'(shift_q), ODD) ^ rx_s;
          state_d     = ST_STOP;
        end
      end

      ST_STOP: begin
        // Results are published here and the FSM is back in IDLE in time
        // to catch a start bit that follows the stop bit directly.
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          data_d  = shift_q;
          perr_d  = perr_pend_q;
          ferr_d  = (rx_s != STOP_LVL);
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
      armed_q     <= 1'b0;
      flush_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      perr_pend_q <= perr_pend_d;
      armed_q     <= armed_d;
      flush_q     <= flush_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_parity_uart_rx.sv
// Bench for parity_uart_rx: an even-parity and an odd-parity receiver share one
// line; a frame-level scoreboard predicts every valid pulse, its cycle and flags.
module tb_parity_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int VALID_LAT = 2 + CPB / 2 + (DB + 2) * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic [DB-1:0] data_e, data_od;
  logic          valid_e, valid_od, perr_e, perr_od, ferr_e, ferr_od, busy_e, busy_od;

  always #5 clk = ~clk;

  parity_uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(0)) dut_even (
    .clk(clk), .rst_n(rst_n), .rx_i(rx), .data_o(data_e), .valid_o(valid_e),
    .parity_err_o(perr_e), .frame_err_o(ferr_e), .busy_o(busy_e));

  parity_uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .rx_i(rx), .data_o(data_od), .valid_o(valid_od),
    .parity_err_o(perr_od), .frame_err_o(ferr_od), .busy_o(busy_od));

  typedef struct {
    logic [DB-1:0] data;
    logic          perr_e;
    logic          perr_o;
    logic          ferr;
    int            cyc;
  } exp_t;

  typedef struct {
    logic [DB-1:0] data;
    logic          pbit;
    logic          stopb;
    logic          perr_e;
    logic          perr_o;
    logic          ferr;
  } vec_t;

  exp_t expq[$];
  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_v = -1;
  int   prev_v = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    exp_t e;
    if (valid_e || valid_od) begin
      prev_v = last_v;
      last_v = cyc;
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got valid at cycle %0d expected none", cyc);
      end else begin
        e = expq.pop_front();
        chk("valid_even", valid_e, 1);
        chk("valid_odd", valid_od, 1);
        chk("valid_cycle", cyc, e.cyc);
        chk("data_even", data_e, e.data);
        chk("data_odd", data_od, e.data);
        chk("perr_even", perr_e, e.perr_e);
        chk("perr_odd", perr_od, e.perr_o);
        chk("ferr_even", ferr_e, e.ferr);
        chk("ferr_odd", ferr_od, e.ferr);
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic stopb);
    exp_t e;
    int   ones;
    ones     = $countones(d) + int'(p);
    e.data   = d;
    e.perr_e = (ones % 2) != 0;
    e.perr_o = (ones % 2) == 0;
    e.ferr   = !stopb;
    e.cyc    = cyc + 1 + VALID_LAT;
    expq.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(stopb);
    rx = 1'b1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_data_even"}, data_e, 0);
    chk({tag, "_data_odd"}, data_od, 0);
    chk({tag, "_valid"}, {valid_e, valid_od}, 0);
    chk({tag, "_perr"}, {perr_e, perr_od}, 0);
    chk({tag, "_ferr"}, {ferr_e, ferr_od}, 0);
    chk({tag, "_busy"}, {busy_e, busy_od}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [DB-1:0] held;
    logic [DB-1:0] rd;
    logic          rp, rs;
    int            wait_n;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset held with the line toggling.
    repeat (20) begin
      @(posedge clk);
      #1 rx = $urandom_range(0, 1);
    end
    chk_outputs_zero("reset");
    @(posedge clk);
    #1 rx = 1'b1;
    rst_n = 1'b1;
    idle(10);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].pbit, vecs[i].stopb);
      chk($sformatf("vec%0d_data_even", i), data_e, vecs[i].data);
      chk($sformatf("vec%0d_data_odd", i), data_od, vecs[i].data);
      chk($sformatf("vec%0d_perr_even", i), perr_e, vecs[i].perr_e);
      chk($sformatf("vec%0d_perr_odd", i), perr_od, vecs[i].perr_o);
      chk($sformatf("vec%0d_ferr", i), {ferr_e, ferr_od}, {vecs[i].ferr, vecs[i].ferr});
      idle(20);
    end

    // Short low pulses are rejected as false starts.
    held = vecs[5].data;
    foreach (vecs[k]) begin end
    for (int g = 0; g < 2; g++) begin
      wait_n = (g == 0) ? 4 : CPB / 2 - 1;
      rx = 1'b0;
      repeat (wait_n) @(posedge clk);
      #1 rx = 1'b1;
      chk($sformatf("glitch%0d_busy_high", wait_n), {busy_e, busy_od}, 2'b11);
      repeat (12) @(posedge clk);
      #1;
      chk($sformatf("glitch%0d_busy_low", wait_n), {busy_e, busy_od}, 2'b00);
      chk($sformatf("glitch%0d_data_held", wait_n), data_e, held);
      idle(10);
    end

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    chk("b2b_spacing", last_v - prev_v, 11 * CPB);
    idle(5);

    for (int n = 0; n < 40; n++) begin
      rd = DB'($urandom);
      rp = $urandom_range(0, 1);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rd, rp, rs);
      idle(rs ? $urandom_range(0, 5) : 20);
    end
    idle(20);

    // Reset in the middle of a frame, released while the line is low.
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20);
    chk("pre_reset_data", data_e, 8'h3C);
    chk("pre_reset_flags", {perr_e, ferr_e}, 2'b11);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("unarmed_busy", {busy_e, busy_od}, 2'b00);
    idle(20);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("post_reset_data", data_e, 8'h5A);
    idle(5);

    wait_n = 0;
    while (expq.size() != 0 && wait_n < 300) begin
      @(posedge clk);
      wait_n++;
    end
    chk("all_frames_received", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_uart_rx.md
# parity_uart_rx

Serial receiver for the team's XOR-parity UART framing: 1 start bit, DATA_BITS data bits LSB first, 1 parity bit, 1 stop bit. It oversamples an asynchronous line input, checks parity by XOR-reduction and stop-bit level, and presents each received word with a one-cycle valid strobe and error flags. It sits at the receive end of the serial link, opposite the parity transmitter.

## Interface
- CLKS_PER_BIT, 16, clock cycles per bit; even, ≥ 4
- DATA_BITS, 8, data bits per frame; 5..9
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rx_i  in  1  asynchronous serial line; idles high
- data_o  out  DATA_BITS  last received word; held until the next frame completes
- valid_o  out  1  one-cycle pulse per completed frame
- parity_err_o  out  1  parity mismatch on last frame; updated with valid_o, then held
- frame_err_o  out  1  stop bit sampled low on last frame; updated with valid_o, then held
- busy_o  out  1  high whenever the FSM is not in IDLE

## Operation
- rx_i passes through a 2-flop synchronizer. Both flops reset to 1.
- The `armed` flag clears on reset. It sets the first time the synchronized line is seen high. IDLE ignores a low line while `armed` = 0.
- FSM states: IDLE, START, DATA, PARITY, STOP. The bit counter `cnt` is sized $clog2(CLKS_PER_BIT) and cleared on every state entry.
- IDLE: when `armed` and the synchronized line is 0, go to START.
- START: sample when cnt == CLKS_PER_BIT/2-1.
  - Line 1: false start; return to IDLE with no outputs.
  - Line 0: go to DATA.
- DATA: sample when cnt == CLKS_PER_BIT-1 and shift into the data register LSB first. After DATA_BITS samples, go to PARITY.
- PARITY: sample when cnt == CLKS_PER_BIT-1. Error when (^data) ^ parity_bit ^ PARITY_ODD = 1. Go to STOP.
- STOP: sample when cnt == CLKS_PER_BIT-1.
  - On that edge: valid_o = 1, load data_o, set parity_err_o from the parity check, set frame_err_o = ~stop_bit.
  - Return to IDLE on the same edge.
- valid_o pulses even when an error flag is set.
- Frames may arrive back to back: a start edge right after the mid-stop sample is accepted.

## Timing
- Reset values: data_o = 0, valid_o = 0, parity_err_o = 0, frame_err_o = 0, busy_o = 0. FSM = IDLE, armed = 0.
- Edge E0 is the first rising edge at which rx_i is sampled low:
  - FSM enters START at E0+2.
  - valid_o is high for exactly one cycle, following edge E0 + 2 + CLKS_PER_BIT/2 + (DATA_BITS+2)·CLKS_PER_BIT. Defaults: E0+170.
- busy_o is decoded from the state register: high from E0+2 until the valid edge or false-start edge.
- Rejection threshold: a low pulse on rx_i shorter than CLKS_PER_BIT/2 cycles is rejected as a false start.
- Reset asserted mid-frame:
  - All outputs go to reset values immediately; the frame is discarded with no valid_o.
  - After release, no frame starts until the line has been seen high.
- All outputs are registered except busy_o, which decodes registered state only.

## Structure
- Shared package `parity_uart_pkg`: state encoding localparams (IDLE, START, DATA, PARITY, STOP), frame constants (start = 0, stop = 1, idle = 1), and a parity helper function. The transmitter shares this package.
- Sub-module `sync_2ff`: parameterized reset value, reused by the other line inputs.
- All timing, shift and check logic lives in one FSM in parity_uart_rx.

## Test plan
- Reset: hold rst_n = 0 with rx_i toggling → all outputs 0, busy_o = 0, no valid_o.
- Defaults; frame 0xA5 with parity 0 and stop 1 → valid_o at E0+170, data_o = 0xA5, parity_err_o = 0, frame_err_o = 0.
- Frame 0xA5 with parity bit 1 → valid_o, data_o = 0xA5, parity_err_o = 1. Repeat with PARITY_ODD = 1 and parity 1 → parity_err_o = 0.
- Frame 0x3C with stop bit 0 → valid_o, data_o = 0x3C, frame_err_o = 1. The next clean frame 0x01 clears frame_err_o.
- Glitch: rx_i low for 4 cycles → busy_o high then low at the start sample, no valid_o, data_o unchanged.
- Back-to-back 0x00 then 0xFF with no idle gap → two valid_o pulses exactly 11·16 = 176 cycles apart. Also: assert rst_n mid-frame and release with rx_i low → no valid_o until rx_i goes high, then a clean frame is received.
